// File: rtl/mips_gpio_pkg.sv
// Shared constants for the mips_gpio peripheral: register offsets, I/O widths
// and the active-low 7-segment decode table.
package mips_gpio_pkg;

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned NUM_SW  = 10;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HEX_W   = 16;

  localparam logic [ADDR_W-1:0] OFF_HEX   = 3'd0;
  localparam logic [ADDR_W-1:0] OFF_LED   = 3'd1;
  localparam logic [ADDR_W-1:0] OFF_SW    = 3'd2;
  localparam logic [ADDR_W-1:0] OFF_BTN   = 3'd3;
  localparam logic [ADDR_W-1:0] OFF_EDGE  = 3'd4;
  localparam logic [ADDR_W-1:0] OFF_IRQEN = 3'd5;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg7(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One push button: 2-flop synchronizer on the inverted (active-high) level,
// consecutive-disagreement counter and accepted stable state.
module gpio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic stable,
  output logic press_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ  = sync2 != stable;
  assign accept  = differ && (cnt >= CNT_LAST);
  assign press_c = accept & sync2;

  // Counter restarts on any agreement and after each accepted change, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mips_gpio.sv
// Memory-mapped GPIO for a MIPS SoC: HEX displays, LEDs, switches, debounced
// buttons with press-edge latch. Define GPIO_IRQ_EN to add IRQEN and the irq line.
module mips_gpio
  import mips_gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [9:0]  sw_in,
  input  logic [2:0]  btn_in,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic [9:0]  ledg,
  output logic        irq
);

  logic [HEX_W-1:0]   hex_q;
  logic [NUM_SW-1:0]  led_q;
  logic [NUM_BTN-1:0] edge_q;
  logic [NUM_SW-1:0]  sw_s1;
  logic [NUM_SW-1:0]  sw_s2;
  logic [NUM_BTN-1:0] btn_stable;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] edge_clr;
  logic [NUM_BTN-1:0] irqen_rd;
  logic [DATA_W-1:0]  rd_val;
  logic               wr;
  logic               rd;
  logic               unused_wdata;

  assign wr       = cs & we;
  assign rd       = cs & ~we;
  assign edge_clr = (wr && addr == OFF_EDGE) ? wdata[NUM_BTN-1:0] : '0;
  assign unused_wdata = ^wdata[DATA_W-1:HEX_W];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_n  (btn_in[i]),
      .stable (btn_stable[i]),
      .press_c(btn_press[i])
    );
  end

  // Bus registers; a press wins over a simultaneous write-1-clear of its EDGE bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q  <= '0;
      led_q  <= '0;
      edge_q <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      rdata  <= '0;
    end else begin
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      edge_q <= (edge_q & ~edge_clr) | btn_press;
      if (wr && addr == OFF_HEX) hex_q <= wdata[HEX_W-1:0];
      if (wr && addr == OFF_LED) led_q <= wdata[NUM_SW-1:0];
      if (rd) rdata <= rd_val;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NUM_BTN-1:0] irqen_q;

  assign irqen_rd = irqen_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irqen_q <= '0;
      irq     <= 1'b0;
    end else begin
      irq <= |(edge_q & irqen_q);
      if (wr && addr == OFF_IRQEN) irqen_q <= wdata[NUM_BTN-1:0];
    end
  end
`else
  assign irqen_rd = '0;
  assign irq      = 1'b0;
`endif

  // Read mux; unmapped offsets and unused upper bits read as zero.
  always_comb begin
    rd_val = '0;
    case (addr)
      OFF_HEX:   rd_val = DATA_W'(hex_q);
      OFF_LED:   rd_val = DATA_W'(led_q);
      OFF_SW:    rd_val = DATA_W'(sw_s2);
      OFF_BTN:   rd_val = DATA_W'(btn_stable);
      OFF_EDGE:  rd_val = DATA_W'(edge_q);
      OFF_IRQEN: rd_val = DATA_W'(irqen_rd);
      default:   rd_val = '0;
    endcase
  end

  assign hex0 = seg7(hex_q[3:0]);
  assign hex1 = seg7(hex_q[7:4]);
  assign hex2 = seg7(hex_q[11:8]);
  assign hex3 = seg7(hex_q[15:12]);
  assign ledg = led_q;

endmodule

// File: doc/mips_gpio.md
MIPS_GPIO -- requirements
Module: mips_gpio

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles before a button change is accepted (10 ms at 50 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cs  input  1  bus select from CPU data path, one-cycle strobe.
REQ-005 we  input  1  write enable, qualified by cs.
REQ-006 addr  input  3  word offset (CPU address bits [4:2]).
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  registered read data.
REQ-009 sw_in  input  10  raw slide switches, asynchronous.
REQ-010 btn_in  input  3  raw push buttons, asynchronous, active-low.
REQ-011 hex3, hex2, hex1, hex0  output  7 each  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 ledg  output  10  green LEDs, active-high.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Register map: 0 HEX (rw, bits[15:0], nibble k drives hexk); 1 LED (rw, bits[9:0]); 2 SW (ro); 3 BTN (ro, debounced, active-high); 4 EDGE (rw1c, bits[2:0]); 5 IRQEN (rw, bits[2:0]); 6-7 unmapped.
REQ-015 Write occurs in the cycle cs&we is high; register updates on that clock edge.
REQ-016 Read: cs&!we captures addressed value into rdata at that edge; rdata valid the following cycle, held until the next read.
REQ-017 Unmapped reads return 0; writes to ro or unmapped offsets are ignored; unused upper bits read 0.
REQ-018 sw_in and btn_in each pass a 2-flop synchronizer; SW returns the second-stage value (2-cycle latency).
REQ-019 Per button: stable state changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears that button's counter.
REQ-020 Debounce counter saturates at DEBOUNCE_CYCLES; no wrap-around.
REQ-021 Stable 0->1 transition (press) sets the EDGE bit that cycle; release does not.
REQ-022 EDGE write-1-clears per bit; a press in the same cycle as a clear of that bit leaves it set.
REQ-023 hexk = 7-segment pattern of HEX nibble k: 0=1000000, 1=1111001, ..., 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; combinational from register.
REQ-024 ledg = LED register bits directly.

Reset
REQ-025 reset clears HEX, LED, EDGE, IRQEN, rdata, debounce counters, stable states to 0; synchronizer flops reset to released (inverted level 0).
REQ-026 After reset hex3..hex0 = 1000000, ledg = 0, irq = 0.
REQ-027 reset mid-debounce discards the partial count; a held button needs a full DEBOUNCE_CYCLES after reset release.

Configuration
REQ-028 With GPIO_IRQ_EN defined: irq = |(EDGE & IRQEN), registered, asserted the cycle after the EDGE bit sets.
REQ-029 Without GPIO_IRQ_EN: irq tied 0, IRQEN reads 0, writes to it ignored, no IRQEN flops.

Structure
REQ-030 Package mips_gpio_pkg holds register offset constants, the 16-entry segment table, button count (3) and switch count (10).
REQ-031 One sub-module gpio_debounce (synchronizer + counter + stable state for one button), instantiated per button.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 Reset asserted 3 cycles -> hex0..3 = 1000000, ledg = 0, rdata = 0, irq = 0.
REQ-033 Write HEX=0x00A5 then LED=0x3FF, read HEX -> hex0=0010010, hex1=0001000, hex2=hex3=1000000, ledg=0x3FF, rdata=0x000000A5 one cycle after the read strobe.
REQ-034 btn_in[0] low, bouncing high for 1 cycle every 3 -> BTN stays 0, EDGE stays 0; held low 6+ cycles -> BTN=0x1, EDGE=0x1.
REQ-035 IRQEN=0x1, press button 0 -> irq=1 (GPIO_IRQ_EN defined) or 0 (undefined); write EDGE=0x1 -> EDGE=0, irq drops next cycle.
REQ-036 Clear EDGE bit 1 in the same cycle button 1 press is accepted -> EDGE bit 1 reads 1.
REQ-037 sw_in=0x2AA, read SW 3+ cycles later -> rdata=0x2AA; read offset 7 -> rdata=0; write offset 2 -> no change.
